// File: rtl/ysyx_22041211_ifu_fsm_if.sv
`timescale 1ns/1ps
// ysyx_22041211_ifu_fsm_if
//   Bundles every handshake and bus signal of the multi-cycle fetch unit.
//   The signal names are written from the IFU's point of view.
//   master modport: the IFU.
//   slave modport:  the environment (memory, decoder and commit stage).
//
//   Memory read channel:
//     arvalid_o / araddr_o / arready_i    fetch request
//     rvalid_i / rdata_i / rresp_i / rready_o    fetch response
//   Decode channel:
//     inst_valid_o / inst_o / inst_pc_o / inst_ready_i
//   Commit channel:
//     commit_valid_i / next_pc_i
//   Status:
//     pc_o          architectural PC
//     fetch_err_o   sticky fault flag
interface ysyx_22041211_ifu_fsm_if #(
    parameter int unsigned ADDR_LEN = 32,
    parameter int unsigned DATA_LEN = 32
);
    logic                arvalid_o;
    logic [ADDR_LEN-1:0] araddr_o;
    logic                arready_i;
    logic                rvalid_i;
    logic [DATA_LEN-1:0] rdata_i;
    logic [1:0]          rresp_i;
    logic                rready_o;

    logic                inst_valid_o;
    logic [DATA_LEN-1:0] inst_o;
    logic [ADDR_LEN-1:0] inst_pc_o;
    logic                inst_ready_i;

    logic                commit_valid_i;
    logic [ADDR_LEN-1:0] next_pc_i;

    logic [ADDR_LEN-1:0] pc_o;
    logic                fetch_err_o;

    modport master (
        output arvalid_o, araddr_o, rready_o,
        output inst_valid_o, inst_o, inst_pc_o,
        output pc_o, fetch_err_o,
        input  arready_i, rvalid_i, rdata_i, rresp_i,
        input  inst_ready_i, commit_valid_i, next_pc_i
    );

    modport slave (
        input  arvalid_o, araddr_o, rready_o,
        input  inst_valid_o, inst_o, inst_pc_o,
        input  pc_o, fetch_err_o,
        output arready_i, rvalid_i, rdata_i, rresp_i,
        output inst_ready_i, commit_valid_i, next_pc_i
    );
endinterface

// File: rtl/ysyx_22041211_ifu_fsm.sv
`timescale 1ns/1ps
// ysyx_22041211_ifu_fsm
//   A multi-cycle instruction fetch unit that sits just before the decoder.
//   It keeps exactly one instruction in flight:
//     1. Request the word at pc_o over the read channel.
//     2. Latch the response.
//     3. Hand {inst_pc_o, inst_o} to decode over a valid/ready pair.
//     4. Wait for commit to return the next PC.
//   Any misaligned PC or error response stops the unit in S_ERR until reset.
//
//   Ports:
//     clk   system clock
//     rst   asynchronous reset, active-low
//     bus   ysyx_22041211_ifu_fsm_if.master
//           (read channel, decode channel, commit channel, pc_o, fetch_err_o)
//
//   Optional build macro: YSYX_22041211_IFU_TIMEOUT_EN
//     When defined, a fetch that waits TIMEOUT_CYC cycles in S_REQ/S_RESP
//     without a handshake faults into S_ERR.
//     When undefined, the unit waits for memory indefinitely.
module ysyx_22041211_ifu_fsm #(
    parameter int unsigned         ADDR_LEN    = 32,
    parameter int unsigned         DATA_LEN    = 32,
    parameter logic [ADDR_LEN-1:0] RESET_PC    = 32'h8000_0000,
    parameter int unsigned         TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_22041211_ifu_fsm_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_OUT,
        S_WAIT,
        S_ERR
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_LEN-1:0] pc;
    logic [DATA_LEN-1:0] inst;
    logic [ADDR_LEN-1:0] inst_pc;
    logic                pc_we;
    logic                inst_we;
    logic                timeout_hit;

    // Outputs come straight from the state register and the data registers.
    // This keeps every input-to-output path broken by a flop.
    assign bus.arvalid_o    = (state == S_REQ);
    assign bus.araddr_o     = pc;
    assign bus.rready_o     = (state == S_RESP);
    assign bus.inst_valid_o = (state == S_OUT);
    assign bus.inst_o       = inst;
    assign bus.inst_pc_o    = inst_pc;
    assign bus.pc_o         = pc;
    assign bus.fetch_err_o  = (state == S_ERR);

`ifdef YSYX_22041211_IFU_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);

    logic [31:0] wait_cnt;
    logic        fetch_hs;

    // A handshake in the same cycle the count expires takes priority over the timeout.
    assign fetch_hs    = ((state == S_REQ) && bus.arready_i) ||
                         ((state == S_RESP) && bus.rvalid_i);
    assign timeout_hit = ((state == S_REQ) || (state == S_RESP)) &&
                         !fetch_hs && (wait_cnt == TIMEOUT_LAST);

    // The count is 0 in the first S_REQ cycle of each fetch.
    // It keeps running through S_RESP, so the budget covers the whole round trip.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if ((state_nxt == S_REQ) && (state != S_REQ)) begin
            wait_cnt <= '0;
        end else if ((state == S_REQ) || (state == S_RESP)) begin
            wait_cnt <= wait_cnt + 32'd1;
        end
    end
`else
    localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;

    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            inst    <= '0;
            inst_pc <= '0;
        end else begin
            state <= state_nxt;
            if (pc_we) begin
                pc <= bus.next_pc_i;
            end
            if (inst_we) begin
                inst    <= bus.rdata_i;
                inst_pc <= pc;
            end
        end
    end

    // Commit is honoured only in S_WAIT.
    // A commit pulse in any other state, including the S_OUT handshake cycle, is dropped.
    always_comb begin
        state_nxt = state;
        pc_we     = 1'b0;
        inst_we   = 1'b0;
        unique case (state)
            S_IDLE: begin
                state_nxt = (pc[1:0] == 2'b00) ? S_REQ : S_ERR;
            end
            S_REQ: begin
                if (bus.arready_i) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rvalid_i) begin
                    if (bus.rresp_i == 2'b00) begin
                        inst_we   = 1'b1;
                        state_nxt = S_OUT;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
            end
            S_OUT: begin
                if (bus.inst_ready_i) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.commit_valid_i) begin
                    pc_we     = 1'b1;
                    state_nxt = (bus.next_pc_i[1:0] == 2'b00) ? S_REQ : S_ERR;
                end
            end
            S_ERR: begin
                state_nxt = S_ERR;
            end
            default: begin
                state_nxt = S_ERR;
            end
        endcase
        if (timeout_hit) begin
            state_nxt = S_ERR;
        end
    end

endmodule

// File: tb/tb_ysyx_22041211_ifu_fsm.sv
`timescale 1ns/1ps
// tb_ysyx_22041211_ifu_fsm
//   Directed scenarios with literal expectations, followed by randomized
//   episodes.
//   A transaction-level model of the fetch protocol checks every output on
//   every cycle.
module tb_ysyx_22041211_ifu_fsm;

    localparam int unsigned ADDR_LEN = 32;
    localparam int unsigned DATA_LEN = 32;
    localparam int unsigned TMO      = 8;
    localparam logic [31:0] RST_PC   = 32'h8000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks    = 0;
    int fails     = 0;
    int delivered = 0;

    // Model: which protocol obligation is currently open.
    bit          m_boot    = 1'b1;
    bit          m_req     = 1'b0;
    bit          m_resp    = 1'b0;
    bit          m_out     = 1'b0;
    bit          m_exec    = 1'b0;
    bit          m_fault   = 1'b0;
    int          m_cnt     = 0;
    logic [31:0] m_pc      = RST_PC;
    logic [31:0] m_inst    = '0;
    logic [31:0] m_inst_pc = '0;

    ysyx_22041211_ifu_fsm_if #(.ADDR_LEN(ADDR_LEN), .DATA_LEN(DATA_LEN)) bus ();

    ysyx_22041211_ifu_fsm #(
        .ADDR_LEN   (ADDR_LEN),
        .DATA_LEN   (DATA_LEN),
        .RESET_PC   (RST_PC),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit ar, input bit rv, input logic [31:0] rd,
                                 input logic [1:0] rr, input bit ir, input bit cv,
                                 input logic [31:0] np);
        bus.arready_i      = ar;
        bus.rvalid_i       = rv;
        bus.rdata_i        = rd;
        bus.rresp_i        = rr;
        bus.inst_ready_i   = ir;
        bus.commit_valid_i = cv;
        bus.next_pc_i      = np;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic modelFault();
        m_fault = 1'b1;
        m_req   = 1'b0;
        m_resp  = 1'b0;
        m_out   = 1'b0;
        m_exec  = 1'b0;
    endtask

    task automatic modelReset();
        m_boot    = 1'b1;
        m_req     = 1'b0;
        m_resp    = 1'b0;
        m_out     = 1'b0;
        m_exec    = 1'b0;
        m_fault   = 1'b0;
        m_cnt     = 0;
        m_pc      = RST_PC;
        m_inst    = '0;
        m_inst_pc = '0;
    endtask

    task automatic modelStep();
        bit hs;
        bit timed_out;
        if (m_fault) return;
        if (m_boot) begin
            m_boot = 1'b0;
            if (m_pc[1:0] != 2'b00) modelFault();
            else begin
                m_req = 1'b1;
                m_cnt = 0;
            end
        end else if (m_req || m_resp) begin
            hs = m_req ? bus.arready_i : bus.rvalid_i;
            timed_out = 1'b0;
`ifdef YSYX_22041211_IFU_TIMEOUT_EN
            m_cnt++;
            timed_out = !hs && (m_cnt >= TMO);
`endif
            if (timed_out) modelFault();
            else if (hs && m_req) begin
                m_req  = 1'b0;
                m_resp = 1'b1;
            end else if (hs) begin
                if (bus.rresp_i != 2'b00) modelFault();
                else begin
                    m_inst    = bus.rdata_i;
                    m_inst_pc = m_pc;
                    m_resp    = 1'b0;
                    m_out     = 1'b1;
                end
            end
        end else if (m_out) begin
            if (bus.inst_ready_i) begin
                delivered++;
                m_out  = 1'b0;
                m_exec = 1'b1;
            end
        end else if (m_exec) begin
            if (bus.commit_valid_i) begin
                m_pc   = bus.next_pc_i;
                m_exec = 1'b0;
                if (bus.next_pc_i[1:0] != 2'b00) modelFault();
                else begin
                    m_req = 1'b1;
                    m_cnt = 0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) modelReset();
        else modelStep();
        #1;
        checkOutput("arvalid",    32'(bus.arvalid_o),    32'(m_req));
        checkOutput("araddr",     bus.araddr_o,          m_pc);
        checkOutput("rready",     32'(bus.rready_o),     32'(m_resp));
        checkOutput("inst_valid", 32'(bus.inst_valid_o), 32'(m_out));
        checkOutput("inst",       bus.inst_o,            m_inst);
        checkOutput("inst_pc",    bus.inst_pc_o,         m_inst_pc);
        checkOutput("pc",         bus.pc_o,              m_pc);
        checkOutput("fetch_err",  32'(bus.fetch_err_o),  32'(m_fault));
    end

    initial begin
        // Zero-wait fetch, a branch commit, a stray commit in S_RESP, then an error response.
        resetDut();
        checkOutput("t1_c0_arvalid", 32'(bus.arvalid_o), 0);
        checkOutput("t1_c0_pc", bus.pc_o, 32'h8000_0000);
        checkOutput("t1_c0_err", 32'(bus.fetch_err_o), 0);
        step();
        checkOutput("t1_c1_arvalid", 32'(bus.arvalid_o), 1);
        checkOutput("t1_c1_araddr", bus.araddr_o, 32'h8000_0000);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        step();
        checkOutput("t1_c2_rready", 32'(bus.rready_o), 1);
        checkOutput("t1_c2_inst_valid", 32'(bus.inst_valid_o), 0);
        applyStimulus(0, 1, 32'h0000_0413, 0, 0, 0, 0);
        step();
        checkOutput("t1_c3_inst_valid", 32'(bus.inst_valid_o), 1);
        checkOutput("t1_c3_inst", bus.inst_o, 32'h0000_0413);
        checkOutput("t1_c3_inst_pc", bus.inst_pc_o, 32'h8000_0000);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        step();
        checkOutput("t3_wait_inst_valid", 32'(bus.inst_valid_o), 0);
        checkOutput("t3_wait_arvalid", 32'(bus.arvalid_o), 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h8000_0100);
        step();
        checkOutput("t3_branch_araddr", bus.araddr_o, 32'h8000_0100);
        checkOutput("t3_branch_arvalid", 32'(bus.arvalid_o), 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h1234_5678);
        step();
        checkOutput("t3_resp_commit_pc", bus.pc_o, 32'h8000_0100);
        checkOutput("t3_resp_rready", 32'(bus.rready_o), 1);
        applyStimulus(0, 1, 32'h0000_0013, 2'b10, 0, 0, 0);
        step();
        checkOutput("t4_rresp_err", 32'(bus.fetch_err_o), 1);
        checkOutput("t4_rresp_pc", bus.pc_o, 32'h8000_0100);
        applyStimulus(1, 1, 0, 0, 1, 1, 32'h8000_0000);
        repeat (5) step();
        checkOutput("t4_rresp_err_sticky", 32'(bus.fetch_err_o), 1);
        checkOutput("t4_rresp_arvalid", 32'(bus.arvalid_o), 0);

        // Misaligned commit target faults and leaves the bad address on pc_o.
        resetDut();
        step();
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 1, 32'h0010_0093, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h8000_0102);
        step();
        checkOutput("t4_misalign_err", 32'(bus.fetch_err_o), 1);
        checkOutput("t4_misalign_pc", bus.pc_o, 32'h8000_0102);
        applyStimulus(1, 1, 0, 0, 1, 0, 0);
        repeat (5) step();
        checkOutput("t4_misalign_arvalid", 32'(bus.arvalid_o), 0);
        checkOutput("t4_misalign_inst_valid", 32'(bus.inst_valid_o), 0);

        // Slow memory and a slow decoder; the request goes out once and the instruction is handed over once.
        resetDut();
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("t2_araddr_stable", bus.araddr_o, 32'h8000_0000);
            checkOutput("t2_arvalid_held", 32'(bus.arvalid_o), 1);
        end
        step();
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(1, 1, 32'h00A0_0113, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            applyStimulus(1, 0, 0, 0, 0, 0, 0);
            checkOutput("t2_inst_stable", bus.inst_o, 32'h00A0_0113);
            checkOutput("t2_inst_valid_held", 32'(bus.inst_valid_o), 1);
            checkOutput("t2_no_second_req", 32'(bus.arvalid_o), 0);
        end
        step();
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            applyStimulus(1, 0, 0, 0, 1, 0, 0);
            checkOutput("t2_no_dup_valid", 32'(bus.inst_valid_o), 0);
            checkOutput("t2_no_req_before_commit", 32'(bus.arvalid_o), 0);
        end

        // Asynchronous reset during S_RESP; the stale rvalid is ignored after release.
        resetDut();
        step();
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 1, 32'h0000_0413, 0, 0, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        step();
        applyStimulus(0, 0, 0, 0, 0, 1, 32'h8000_0040);
        step();
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        step();
        checkOutput("t5_pre_rready", 32'(bus.rready_o), 1);
        applyStimulus(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_async_rready", 32'(bus.rready_o), 0);
        checkOutput("t5_async_pc", bus.pc_o, 32'h8000_0000);
        checkOutput("t5_async_inst", bus.inst_o, 32'h0);
        checkOutput("t5_async_inst_pc", bus.inst_pc_o, 32'h0);
        checkOutput("t5_async_inst_valid", 32'(bus.inst_valid_o), 0);
        checkOutput("t5_async_arvalid", 32'(bus.arvalid_o), 0);
        step();
        rst_n = 1'b1;
        step();
        checkOutput("t5_restart_araddr", bus.araddr_o, 32'h8000_0000);
        checkOutput("t5_restart_arvalid", 32'(bus.arvalid_o), 1);
        checkOutput("t5_stale_ignored", 32'(bus.inst_valid_o), 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        step();
        applyStimulus(0, 1, 32'h0000_0513, 0, 0, 0, 0);
        step();
        checkOutput("t5_refetch_inst", bus.inst_o, 32'h0000_0513);
        checkOutput("t5_refetch_inst_pc", bus.inst_pc_o, 32'h8000_0000);

        // arready held low: timeout fault when enabled, otherwise an endless wait.
        resetDut();
        repeat (8) step();
        checkOutput("t6_c8_arvalid", 32'(bus.arvalid_o), 1);
        checkOutput("t6_c8_err", 32'(bus.fetch_err_o), 0);
        step();
`ifdef YSYX_22041211_IFU_TIMEOUT_EN
        checkOutput("t6_c9_err", 32'(bus.fetch_err_o), 1);
        checkOutput("t6_c9_arvalid", 32'(bus.arvalid_o), 0);
`else
        checkOutput("t6_c9_err", 32'(bus.fetch_err_o), 0);
        checkOutput("t6_c9_arvalid", 32'(bus.arvalid_o), 1);
`endif
        repeat (100) step();
`ifdef YSYX_22041211_IFU_TIMEOUT_EN
        checkOutput("t6_long_err", 32'(bus.fetch_err_o), 1);
`else
        checkOutput("t6_long_err", 32'(bus.fetch_err_o), 0);
        checkOutput("t6_long_arvalid", 32'(bus.arvalid_o), 1);
`endif

        // Randomized episodes; the per-cycle model comparison does the checking.
        delivered = 0;
        for (int ep = 0; ep < 10; ep++) begin
            resetDut();
            for (int c = 0; c < 300; c++) begin
                logic [31:0] np;
                int sel;
                step();
                sel = $urandom_range(0, 9);
                np  = (sel == 0) ? 32'hFFFF_FFFC :
                      (sel == 1) ? RST_PC :
                      ($urandom() & 32'hFFFF_FFFC);
                applyStimulus($urandom_range(0, 1) == 1,
                              $urandom_range(0, 1) == 1,
                              $urandom(),
                              ($urandom_range(0, 99) == 0) ? 2'b01 : 2'b00,
                              $urandom_range(0, 1) == 1,
                              $urandom_range(0, 2) == 0,
                              np);
            end
        end
        checkOutput("rand_progress", 32'(delivered > 20), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_22041211_ifu_fsm.md
Name: ysyx_22041211_ifu_fsm

Overview:
- Multi-cycle instruction fetch unit sitting directly upstream of the decoder.
- Replaces the combinational DPI fetch with a handshaked read channel to instruction memory, which can be an SRAM model or an AXI-lite read-only port.
- Hands {pc, inst} to the decode stage over a valid/ready pair.
- Holds the PC until the writeback/commit stage returns the next PC, so exactly one instruction is in flight.

Parameters:
- ADDR_LEN, 32, address/PC width
- DATA_LEN, 32, instruction width
- RESET_PC, 32'h8000_0000, PC loaded on reset
- TIMEOUT_CYC, 1024, cycles to wait for memory response (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- arvalid_o  out  1  fetch request valid
- araddr_o  out  ADDR_LEN  fetch address (equals pc_o)
- arready_i  in  1  memory accepts request
- rvalid_i  in  1  memory response valid
- rdata_i  in  DATA_LEN  fetched instruction
- rresp_i  in  2  response status; 2'b00 = OKAY, anything else = error
- rready_o  out  1  IFU accepts response
- inst_valid_o  out  1  instruction valid to decoder
- inst_o  out  DATA_LEN  instruction to decoder
- inst_pc_o  out  ADDR_LEN  PC of inst_o
- inst_ready_i  in  1  decoder accepts instruction
- commit_valid_i  in  1  writeback finished current instruction
- next_pc_i  in  ADDR_LEN  PC of next instruction (pc+4, branch, jump, or CSR target)
- pc_o  out  ADDR_LEN  current architectural PC
- fetch_err_o  out  1  sticky fetch fault flag

Behaviour:
- Reset is asynchronous and active-low. Asserting rst (low) immediately forces:
  - state=S_IDLE, pc_o=RESET_PC, inst_o=0, inst_pc_o=0, fetch_err_o=0
  - arvalid_o=0, rready_o=0, inst_valid_o=0
- Reset mid-operation aborts any outstanding request or response. No response arriving after reset release is consumed until the next S_RESP.
- States: S_IDLE, S_REQ, S_RESP, S_OUT, S_WAIT, S_ERR.
- S_IDLE:
  - Next edge goes to S_REQ if pc_o[1:0]==0, otherwise S_ERR.
  - So the first arvalid_o rises one cycle after reset release.
- S_REQ:
  - arvalid_o=1, araddr_o=pc_o.
  - araddr_o stays stable while arvalid_o=1 and arready_i=0.
  - arvalid_o&arready_i -> S_RESP.
- S_RESP:
  - rready_o=1.
  - rvalid_i with rresp_i==0: latch inst_o=rdata_i, inst_pc_o=pc_o, go to S_OUT.
  - rvalid_i with rresp_i!=0: go to S_ERR.
  - Zero-wait memory: arready in cycle N and rvalid in cycle N+1 gives inst_valid_o in cycle N+2.
- S_OUT:
  - inst_valid_o=1; inst_o and inst_pc_o are held stable until the handshake.
  - inst_valid_o&inst_ready_i -> S_WAIT.
- S_WAIT:
  - commit_valid_i: pc_o<=next_pc_i.
    - next_pc_i[1:0]!=0 -> S_ERR (pc_o still updates, for diagnosis).
    - Otherwise -> S_REQ.
  - commit_valid_i in any state other than S_WAIT is ignored; pc_o is unchanged.
  - Commit in the same cycle as the S_OUT handshake is not legal (decode precedes commit) and is ignored.
- S_ERR:
  - Terminal: fetch_err_o=1 and all valids 0 until reset.
  - pc_o holds the faulting address.
- pc_o changes only on reset or on commit in S_WAIT.
- Full-width wrap: next_pc_i=32'hFFFF_FFFC is fetched normally; there is no PC arithmetic inside the block.
- rvalid_i while not in S_RESP is ignored (rready_o=0).
- All outputs are registered or decoded from the state register; there is no combinational path from any input to any output.

Optional Feature:
- Macro: YSYX_22041211_IFU_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on entry to S_REQ and increments each cycle in S_REQ or S_RESP.
  - Reaching TIMEOUT_CYC without a completed handshake -> S_ERR, fetch_err_o=1.
  - A handshake in the same cycle the count hits TIMEOUT_CYC wins: no error.
- Undefined:
  - No counter is instantiated; the IFU waits indefinitely in S_REQ/S_RESP.

Test Plan:
1. Reset release, arready_i=1, rvalid_i=1 one cycle later, rdata_i=32'h0000_0413, inst_ready_i=1 -> araddr_o=32'h8000_0000 in cycle 1, inst_valid_o in cycle 3 with inst_o=32'h0000_0413 and inst_pc_o=32'h8000_0000.
2. arready_i delayed 5 cycles and inst_ready_i delayed 3 cycles -> araddr_o and inst_o stable throughout, exactly one request issued, no duplicate inst_valid handshake.
3. Commit with next_pc_i=32'h8000_0100 (branch) -> next araddr_o=32'h8000_0100; a commit_valid_i pulse injected during S_RESP leaves pc_o unchanged.
4. rresp_i=2'b10 on the response, or next_pc_i=32'h8000_0102 -> fetch_err_o=1 and stays high, arvalid_o=0 forever, pc_o shows the faulting address.
5. Drive rst low while in S_RESP -> all outputs return to reset values immediately (asynchronously); the old rvalid_i after release is ignored; the fetch restarts at 32'h8000_0000.
6. With YSYX_22041211_IFU_TIMEOUT_EN defined, TIMEOUT_CYC=8, and arready_i held 0 -> fetch_err_o=1 after 8 cycles in S_REQ. With the macro undefined, the same stimulus keeps arvalid_o=1 for 100+ cycles with no error.
